// File: rtl/echo_pkg.sv
// Shared definitions for the echo-reduction delay line: controller state encoding,
// default geometry and the delay clamp used whenever a new delay is accepted.
package echo_pkg;

  // Default RAM address width (DEPTH = 2**ADDR_W) and power-on delay in samples.
  // The subtract/saturate datapath sizes its sample RAM from these as well.
  localparam int unsigned DEF_ADDR_W        = 10;
  localparam int unsigned DEF_DELAY_SAMPLES = 512;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPrime    = 2'd1,
    StRun      = 2'd2,
    StReconfig = 2'd3
  } echo_state_e;

  // A zero delay would read the slot being written this sample, so it becomes 1;
  // anything beyond the RAM depth is pinned to the oldest slot still held.
  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned max_delay);
    if (req == 0) begin
      return 1;
    end else if (req > max_delay) begin
      return max_delay;
    end
    return req;
  endfunction

endpackage

// File: rtl/echo_delay_ctrl_if.sv
// Bundle between the sample-strobe/config side and the echo delay-line sequencer.
// The master drives run control, sample strobes and config requests; the slave
// (the sequencer) drives the RAM strobes, echo qualifier and status.
interface echo_delay_ctrl_if
  import echo_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic              enable;
  logic              sample_en;
  logic [ADDR_W-1:0] cfg_delay;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              echo_valid;
  logic [ADDR_W-1:0] cur_delay;
  logic              busy;

  modport master (
    output enable,
    output sample_en,
    output cfg_delay,
    output cfg_valid,
    input  cfg_ready,
    input  mem_wr_en,
    input  mem_wr_addr,
    input  mem_rd_en,
    input  mem_rd_addr,
    input  echo_valid,
    input  cur_delay,
    input  busy
  );

  modport slave (
    input  enable,
    input  sample_en,
    input  cfg_delay,
    input  cfg_valid,
    output cfg_ready,
    output mem_wr_en,
    output mem_wr_addr,
    output mem_rd_en,
    output mem_rd_addr,
    output echo_valid,
    output cur_delay,
    output busy
  );

endinterface

// File: rtl/echo_ptr_gen.sv
// Write pointer of the delay-line RAM plus the matching read address.
// The read address is the pointer minus the delay, wrapping naturally mod DEPTH.
module echo_ptr_gen
  import echo_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic [ADDR_W-1:0] delay,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_addr
);

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_d;

  // Step once per issued write; DEPTH-1 rolls over to 0 by truncation.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (advance) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
  end

  // Pointer register; only reset clears it, so history survives re-priming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign wr_ptr  = wr_ptr_q;
  assign rd_addr = wr_ptr_q - delay;

endmodule

// File: rtl/echo_delay_ctrl.sv
// Echo delay-line sequencer. Issues one RAM write per output sample and, once the
// line holds cur_delay samples, one read of the sample cur_delay samples ago.
// echo_valid qualifies the RAM read data one cycle after the read strobe so the
// subtract datapath uses zero echo until the line is primed.
module echo_delay_ctrl
  import echo_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DEF_DELAY = DEF_DELAY_SAMPLES
) (
  input  logic             clk,
  input  logic             rst_n,
  echo_delay_ctrl_if.slave bus
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned MaxDelay = Depth - 1;

  echo_state_e state_q, state_d;

  logic [ADDR_W-1:0] cur_delay_q, cur_delay_d;
  logic [ADDR_W-1:0] pend_delay_q, pend_delay_d;
  logic [ADDR_W-1:0] prime_cnt_q, prime_cnt_d;
  logic [ADDR_W-1:0] prime_cnt_inc;

  logic              wr_en_q, rd_en_q, echo_valid_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;

  logic              cfg_ready;
  logic              busy;
  logic              cfg_fire;
  logic              wr_fire;
  logic              rd_fire;
  logic [ADDR_W-1:0] cfg_clamped;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;

  assign cfg_clamped   = ADDR_W'(clamp_delay(32'(bus.cfg_delay), MaxDelay));
  assign cfg_fire      = bus.cfg_valid & cfg_ready;
  assign prime_cnt_inc = prime_cnt_q + ADDR_W'(1);

  echo_ptr_gen #(
    .ADDR_W (ADDR_W)
  ) u_ptr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (wr_fire),
    .delay   (cur_delay_q),
    .wr_ptr  (wr_ptr),
    .rd_addr (rd_addr)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; dropping enable always wins and returns to idle.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StPrime;
        end
        StPrime: begin
          if (cfg_fire) begin
            state_d = StReconfig;
          end else if (bus.sample_en && (prime_cnt_inc == cur_delay_q)) begin
            // This write completes priming; the next sample can read.
            state_d = StRun;
          end
        end
        StRun: begin
          if (cfg_fire) begin
            state_d = StReconfig;
          end
        end
        StReconfig: begin
          // A sample landing here counts as the first priming write.
          if (bus.sample_en && (pend_delay_q == ADDR_W'(1))) begin
            state_d = StRun;
          end else begin
            state_d = StPrime;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM outputs: handshake, status and which strobes this sample gets.
  always_comb begin
    cfg_ready = 1'b1;
    busy      = 1'b0;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cfg_ready = 1'b1;
      end
      StPrime: begin
        busy    = 1'b1;
        wr_fire = bus.enable & bus.sample_en;
      end
      StRun: begin
        wr_fire = bus.enable & bus.sample_en;
        rd_fire = bus.enable & bus.sample_en;
      end
      StReconfig: begin
        busy      = 1'b1;
        cfg_ready = 1'b0;
        wr_fire   = bus.enable & bus.sample_en;
      end
      default: begin
        cfg_ready = 1'b1;
      end
    endcase
  end

  // Delay and prime-counter next state. A config accepted while the line is
  // running is parked until the reconfig cycle so an in-flight sample keeps the
  // old delay; when idle (or being disabled) it applies straight away.
  always_comb begin
    cur_delay_d  = cur_delay_q;
    pend_delay_d = pend_delay_q;
    prime_cnt_d  = prime_cnt_q;
    if (cfg_fire) begin
      if ((state_q == StIdle) || !bus.enable) begin
        cur_delay_d = cfg_clamped;
      end else begin
        pend_delay_d = cfg_clamped;
      end
    end
    unique case (state_q)
      StIdle: begin
        prime_cnt_d = '0;
      end
      StPrime: begin
        if (wr_fire) begin
          prime_cnt_d = prime_cnt_inc;
        end
      end
      StRun: begin
        prime_cnt_d = prime_cnt_q;
      end
      StReconfig: begin
        cur_delay_d = pend_delay_q;
        prime_cnt_d = wr_fire ? ADDR_W'(1) : '0;
      end
      default: begin
        prime_cnt_d = '0;
      end
    endcase
  end

  // Delay configuration and priming progress registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_delay_q  <= ADDR_W'(DEF_DELAY);
      pend_delay_q <= ADDR_W'(DEF_DELAY);
      prime_cnt_q  <= '0;
    end else begin
      cur_delay_q  <= cur_delay_d;
      pend_delay_q <= pend_delay_d;
      prime_cnt_q  <= prime_cnt_d;
    end
  end

  // RAM strobes one cycle after sample_en; echo_valid trails the read by the
  // single-cycle RAM read latency. Addresses hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      echo_valid_q <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
    end else begin
      wr_en_q      <= wr_fire;
      rd_en_q      <= rd_fire;
      echo_valid_q <= rd_en_q;
      if (wr_fire) begin
        wr_addr_q <= wr_ptr;
      end
      if (rd_fire) begin
        rd_addr_q <= rd_addr;
      end
    end
  end

  assign bus.cfg_ready   = cfg_ready;
  assign bus.busy        = busy;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_addr = wr_addr_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.echo_valid  = echo_valid_q;
  assign bus.cur_delay   = cur_delay_q;

endmodule
